ifetch_queue: RTL and testbench

IFETCH_QUEUE -- requirements
Module: ifetch_queue

---
 rtl/ifetch_queue_pkg.sv | 19 +
 rtl/ifq_fifo.sv | 84 ++++++++
 rtl/ifetch_queue.sv | 166 ++++++++++++++++
 tb/tb_ifetch_queue.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue: FSM state encodings,
// word width, default reset fetch address and an address alignment helper.
package ifetch_queue_pkg;

    localparam int          IFQ_WORD_W   = 32;
    localparam logic [31:0] IFQ_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IFQ_IDLE    = 2'b00,   // no request outstanding
        IFQ_BUSY    = 2'b01,   // request outstanding, result wanted
        IFQ_DISCARD = 2'b10    // request outstanding, result belongs to a flushed stream
    } ifq_state_e;

    // Force a byte address onto a word boundary.
    function automatic logic [IFQ_WORD_W-1:0] ifq_align(input logic [IFQ_WORD_W-1:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Circular buffer holding {pc, instruction} pairs for the fetch queue.
// Wrapping read/write pointers, occupancy count, synchronous clear (flush)
// and asynchronous active-low reset. Overflow/underflow requests are ignored.
module ifq_fifo
    import ifetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Qualify requests so the buffer can never over- or under-run.
    always_comb begin
        pop_ok_s  = pop && (count_q != {CW{1'b0}});
        push_ok_s = push && ((count_q != DEPTH_C) || pop_ok_s);
    end

    // Next-state for storage, pointers and count; clear wins over everything.
    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (clr) begin
            wptr_d  = {PW{1'b0}};
            rptr_d  = {PW{1'b0}};
            count_d = {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_d[wptr_q] = din;
                wptr_d        = wptr_q + PW'(1);
            end
            if (pop_ok_s) begin
                rptr_d = rptr_q + PW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Storage and pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
            wptr_q  <= {PW{1'b0}};
            rptr_q  <= {PW{1'b0}};
            count_q <= {CW{1'b0}};
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    assign dout  = mem_q[rptr_q];
    assign count = count_q;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues one word fetch at a time on the instruction
// bus, buffers returned words with their address and presents them in order.
// A flush empties the queue and redirects fetching; a request still in flight
// at flush time is completed on the bus and its data dropped.
// Optional build macro: IFQ_BYPASS_EN -- an acked word is forwarded straight
// to the outputs when the queue is empty.
module ifetch_queue
    import ifetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = IFQ_RESET_PC
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic [31:0]            IAD,
    output logic                   IACK_n,
    input  logic                   ACKI_n,
    input  logic [31:0]            IDT,
    input  logic                   flush,
    input  logic [31:0]            flush_pc,
    output logic [31:0]            inst_o,
    output logic [31:0]            pc_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    ifq_state_e  state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] iad_q, iad_d;
    logic        iack_n_q, iack_n_d;

    logic [31:0] flush_tgt_s;
    logic        ack_s;
    logic        push_s;
    logic        pop_s;
    logic        fifo_empty_s;
    logic        bypass_take_s;
    logic [CW-1:0] fifo_count_s;
    logic [63:0] fifo_dout_s;

    // Decode bus/datapath handshakes into queue push/pop requests.
    always_comb begin
        flush_tgt_s  = ifq_align(flush_pc);
        ack_s        = !ACKI_n;
        fifo_empty_s = (fifo_count_s == {CW{1'b0}});
`ifdef IFQ_BYPASS_EN
        bypass_take_s = fifo_empty_s && (state_q == IFQ_BUSY) && ack_s && !flush && ready_i;
`else
        bypass_take_s = 1'b0;
`endif
        push_s = (state_q == IFQ_BUSY) && ack_s && !flush && !bypass_take_s;
        pop_s  = !fifo_empty_s && ready_i && !flush;
    end

    // Fetch FSM: request issue, ack handling and flush redirection.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        iad_d      = iad_q;
        iack_n_d   = iack_n_q;
        case (state_q)
            IFQ_IDLE: begin
                if (flush) begin
                    fetch_pc_d = flush_tgt_s;
                end else if (fifo_count_s < DEPTH_C) begin
                    state_d  = IFQ_BUSY;
                    iack_n_d = 1'b0;
                    iad_d    = fetch_pc_q;
                end else begin
                    state_d = IFQ_IDLE;
                end
            end
            IFQ_BUSY: begin
                if (flush) begin
                    fetch_pc_d = flush_tgt_s;
                    if (ack_s) begin
                        state_d  = IFQ_IDLE;
                        iack_n_d = 1'b1;
                    end else begin
                        state_d = IFQ_DISCARD;
                    end
                end else if (ack_s) begin
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    state_d    = IFQ_IDLE;
                    iack_n_d   = 1'b1;
                end else begin
                    state_d = IFQ_BUSY;
                end
            end
            IFQ_DISCARD: begin
                if (flush) begin
                    fetch_pc_d = flush_tgt_s;
                end else begin
                    fetch_pc_d = fetch_pc_q;
                end
                if (ack_s) begin
                    state_d  = IFQ_IDLE;
                    iack_n_d = 1'b1;
                end else begin
                    state_d = IFQ_DISCARD;
                end
            end
            default: begin
                state_d  = IFQ_IDLE;
                iack_n_d = 1'b1;
            end
        endcase
    end

    // FSM, fetch address and bus request registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IFQ_IDLE;
            fetch_pc_q <= RESET_PC;
            iad_q      <= RESET_PC;
            iack_n_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            iad_q      <= iad_d;
            iack_n_q   <= iack_n_d;
        end
    end

    ifq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .push  (push_s),
        .din   ({iad_q, IDT}),
        .pop   (pop_s),
        .dout  (fifo_dout_s),
        .count (fifo_count_s)
    );

    // Head-of-queue presentation, with the optional empty-queue forward path.
    always_comb begin
`ifdef IFQ_BYPASS_EN
        if (fifo_empty_s && (state_q == IFQ_BUSY) && ack_s && !flush) begin
            valid_o = 1'b1;
            inst_o  = IDT;
            pc_o    = iad_q;
        end else begin
            valid_o = !fifo_empty_s;
            inst_o  = fifo_dout_s[31:0];
            pc_o    = fifo_dout_s[63:32];
        end
`else
        valid_o = !fifo_empty_s;
        inst_o  = fifo_dout_s[31:0];
        pc_o    = fifo_dout_s[63:32];
`endif
    end

    assign IAD     = iad_q;
    assign IACK_n  = iack_n_q;
    assign count_o = fifo_count_s;

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: directed scenarios plus a randomized
// run against a transaction-level reference model (queue of {pc, word}).
module tb_ifetch_queue;

    localparam int DEPTH = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] IAD;
    logic        IACK_n;
    logic        ACKI_n = 1'b1;
    logic [31:0] IDT = 32'h0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = 32'h0;
    logic [31:0] inst_o, pc_o;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [2:0]  count_o;

    // second instance with a reset address close to the top of memory
    logic [31:0] w_iad, w_inst, w_pc;
    logic        w_iack_n, w_valid;
    logic        w_acki_n = 1'b1;
    logic [31:0] w_idt = 32'h0;
    logic        w_flush = 1'b0;
    logic [31:0] w_flush_pc = 32'h0;
    logic        w_ready = 1'b1;
    logic [2:0]  w_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n), .IAD(IAD), .IACK_n(IACK_n), .ACKI_n(ACKI_n),
        .IDT(IDT), .flush(flush), .flush_pc(flush_pc), .inst_o(inst_o),
        .pc_o(pc_o), .valid_o(valid_o), .ready_i(ready_i), .count_o(count_o)
    );

    ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clk(clk), .rst_n(rst_n), .IAD(w_iad), .IACK_n(w_iack_n), .ACKI_n(w_acki_n),
        .IDT(w_idt), .flush(w_flush), .flush_pc(w_flush_pc), .inst_o(w_inst),
        .pc_o(w_pc), .valid_o(w_valid), .ready_i(w_ready), .count_o(w_count)
    );

    // ---------------- reference model (transaction level) ----------------
    logic [63:0] m_q[$];       // {pc, word}, head at index 0
    logic [31:0] m_pc;         // next address to fetch
    logic [31:0] m_addr;       // address of the outstanding request
    bit          m_out;        // a request is outstanding
    bit          m_stale;      // outstanding request belongs to a flushed stream
    bit          m_ack;
    int          m_sz;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_pc = RST_PC; m_addr = RST_PC; m_out = 0; m_stale = 0;
        end else begin
            m_ack = m_out && (ACKI_n == 1'b0);
            m_sz  = m_q.size();
            if (flush) begin
                m_q.delete();
                m_pc = flush_pc & 32'hFFFF_FFFC;
                if (m_out) begin
                    if (m_ack) begin m_out = 0; m_stale = 0; end
                    else m_stale = 1;
                end
            end else begin
                if (m_sz > 0 && ready_i) void'(m_q.pop_front());
                if (m_ack) begin
                    if (!m_stale) begin
`ifdef IFQ_BYPASS_EN
                        if (!(m_sz == 0 && ready_i)) m_q.push_back({m_addr, IDT});
`else
                        m_q.push_back({m_addr, IDT});
`endif
                        m_pc = m_pc + 32'd4;
                    end
                    m_out = 0; m_stale = 0;
                end else if (!m_out && m_sz < DEPTH) begin
                    m_out = 1; m_addr = m_pc;
                end
            end
        end
    end

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic do_reset();
        rst_n = 1'b0; ACKI_n = 1'b1; flush = 1'b0; ready_i = 1'b0; w_acki_n = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_iack(output bit ok);
        ok = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (IACK_n === 1'b0) begin ok = 1; break; end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        bit ok; int acks;
        do_reset();
        acks = 0;
        for (int c = 0; c < 40 && acks < 2; c++) begin
            @(negedge clk); ACKI_n = IACK_n; IDT = $urandom; if (!IACK_n) acks++;
        end
        @(negedge clk); ACKI_n = 1'b1;
        wait_iack(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL reset_pre_req: no request seen before reset"); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({IACK_n, IAD, count_o, valid_o, inst_o, pc_o} !== {1'b1, RST_PC, 3'd0, 1'b0, 64'h0}) begin
            n_fail++;
            $display("FAIL reset_values: got iack=%b iad=%h cnt=%0d v=%b inst=%h pc=%h, expected 1 %h 0 0 0 0",
                     IACK_n, IAD, count_o, valid_o, inst_o, pc_o, RST_PC);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (IACK_n !== 1'b0 || IAD !== RST_PC) begin
            n_fail++;
            $display("FAIL reset_first_req: got iack=%b iad=%h, expected 0 %h", IACK_n, IAD, RST_PC);
        end
    endtask

    task automatic test_sequence();
        bit ok; logic [31:0] e, w;
        do_reset(); ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            e = 32'(4 * k);
            wait_iack(ok);
            n_checks++;
            if (!ok || IAD !== e) begin
                n_fail++; $display("FAIL seq_addr%0d: got %h (req=%b), expected %h", k, IAD, ok, e);
            end
            w = $urandom; ACKI_n = 1'b0; IDT = w;
`ifdef IFQ_BYPASS_EN
            #1;
            n_checks++;
            if (valid_o !== 1'b1 || inst_o !== w) begin
                n_fail++; $display("FAIL seq_inst%0d: got v=%b %h, expected 1 %h", k, valid_o, inst_o, w);
            end
            @(negedge clk); ACKI_n = 1'b1;
`else
            @(negedge clk); ACKI_n = 1'b1;
            n_checks++;
            if (valid_o !== 1'b1 || inst_o !== w || pc_o !== e) begin
                n_fail++; $display("FAIL seq_inst%0d: got v=%b %h @%h, expected 1 %h @%h", k, valid_o, inst_o, pc_o, w, e);
            end
`endif
        end
    endtask

    task automatic test_full();
        int acks;
        do_reset(); ready_i = 1'b0;
        acks = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk); ACKI_n = IACK_n; IDT = $urandom; if (!IACK_n) acks++;
        end
        n_checks++;
        if (acks != DEPTH || IACK_n !== 1'b1 || count_o !== 3'd4) begin
            n_fail++; $display("FAIL full_stop: got acks=%0d iack=%b cnt=%0d, expected 4 1 4", acks, IACK_n, count_o);
        end
        ACKI_n = 1'b1; ready_i = 1'b1;
        @(negedge clk); ready_i = 1'b0;
        acks = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk); ACKI_n = IACK_n; if (!IACK_n) acks++;
        end
        n_checks++;
        if (acks != 1 || count_o !== 3'd4) begin
            n_fail++; $display("FAIL full_refill: got acks=%0d cnt=%0d, expected 1 4", acks, count_o);
        end
        ACKI_n = 1'b1;
    endtask

    task automatic test_flush_busy();
        bit ok; bit seen;
        do_reset(); ready_i = 1'b1;
        wait_iack(ok);
        flush = 1'b1; flush_pc = 32'h0000_0103;
        @(negedge clk); flush = 1'b0;
        n_checks++;
        if (IACK_n !== 1'b0 || IAD !== RST_PC) begin
            n_fail++; $display("FAIL flush_hold: got iack=%b iad=%h, expected 0 %h", IACK_n, IAD, RST_PC);
        end
        repeat (2) @(negedge clk);
        ACKI_n = 1'b0; IDT = 32'hDEAD_BEEF;
        @(negedge clk); ACKI_n = 1'b1;
        seen = (valid_o === 1'b1 && inst_o === 32'hDEAD_BEEF);
        wait_iack(ok);
        n_checks++;
        if (!ok || IAD !== 32'h0000_0100) begin
            n_fail++; $display("FAIL flush_next_addr: got %h (req=%b), expected 00000100", IAD, ok);
        end
        ACKI_n = 1'b0; IDT = 32'h1234_5678;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); ACKI_n = 1'b1;
            if (valid_o === 1'b1 && inst_o === 32'hDEAD_BEEF) seen = 1;
        end
        n_checks++;
        if (seen) begin n_fail++; $display("FAIL flush_drop: got flushed word DEADBEEF at head, expected never"); end
    endtask

    task automatic test_flush_ack();
        bit ok; int acks;
        do_reset(); ready_i = 1'b0;
        acks = 0;
        for (int c = 0; c < 40 && acks < 2; c++) begin
            @(negedge clk); ACKI_n = IACK_n; IDT = $urandom; if (!IACK_n) acks++;
        end
        @(negedge clk); ACKI_n = 1'b1;
        wait_iack(ok);
        n_checks++;
        if (!ok || count_o !== 3'd2) begin
            n_fail++; $display("FAIL flushack_pre: got cnt=%0d (req=%b), expected 2", count_o, ok);
        end
        ACKI_n = 1'b0; flush = 1'b1; flush_pc = 32'h0000_2002;
        @(negedge clk); ACKI_n = 1'b1; flush = 1'b0;
        n_checks++;
        if (count_o !== 3'd0 || valid_o !== 1'b0) begin
            n_fail++; $display("FAIL flushack_empty: got cnt=%0d v=%b, expected 0 0", count_o, valid_o);
        end
        wait_iack(ok);
        n_checks++;
        if (!ok || IAD !== 32'h0000_2000) begin
            n_fail++; $display("FAIL flushack_addr: got %h (req=%b), expected 00002000", IAD, ok);
        end
    endtask

    task automatic test_latency();
        bit ok; logic [31:0] w;
        do_reset(); ready_i = 1'b1;
        wait_iack(ok);
        w = 32'hCAFE_0001; ACKI_n = 1'b0; IDT = w;
        #1;
        n_checks++;
`ifdef IFQ_BYPASS_EN
        if (valid_o !== 1'b1 || inst_o !== w || pc_o !== RST_PC) begin
            n_fail++; $display("FAIL lat_bypass: got v=%b %h @%h, expected 1 %h @%h", valid_o, inst_o, pc_o, w, RST_PC);
        end
`else
        if (valid_o !== 1'b0) begin
            n_fail++; $display("FAIL lat_ack_cycle: got valid=%b, expected 0", valid_o);
        end
`endif
        @(negedge clk); ACKI_n = 1'b1;
        n_checks++;
`ifdef IFQ_BYPASS_EN
        if (count_o !== 3'd0) begin
            n_fail++; $display("FAIL lat_bypass_cnt: got %0d, expected 0", count_o);
        end
`else
        if (valid_o !== 1'b1 || inst_o !== w || count_o !== 3'd1) begin
            n_fail++; $display("FAIL lat_next: got v=%b %h cnt=%0d, expected 1 %h 1", valid_o, inst_o, count_o, w);
        end
`endif
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            n_checks++;
            if (IACK_n !== !m_out || (m_out && IAD !== m_addr)) begin
                n_fail++; $display("FAIL rnd_bus c%0d: got iack=%b iad=%h, expected %b %h", c, IACK_n, IAD, !m_out, m_addr);
            end
            n_checks++;
            if (count_o !== 3'(m_q.size()) || valid_o !== (m_q.size() > 0)) begin
                n_fail++; $display("FAIL rnd_count c%0d: got cnt=%0d v=%b, expected %0d", c, count_o, valid_o, m_q.size());
            end
            if (m_q.size() > 0) begin
                n_checks++;
                if ({pc_o, inst_o} !== m_q[0]) begin
                    n_fail++; $display("FAIL rnd_head c%0d: got %h:%h, expected %h", c, pc_o, inst_o, m_q[0]);
                end
            end
            ready_i  = ($urandom_range(0, 2) != 0);
            flush    = ($urandom_range(0, 29) == 0);
            flush_pc = $urandom;
            ACKI_n   = !(m_out && ($urandom_range(0, 2) == 0));
            IDT      = $urandom;
        end
        flush = 1'b0; ACKI_n = 1'b1;
    endtask

    task automatic test_wrap();
        logic [31:0] exp_a [3];
        bit ok;
        exp_a[0] = 32'hFFFF_FFF8; exp_a[1] = 32'hFFFF_FFFC; exp_a[2] = 32'h0000_0000;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            ok = 0;
            for (int c = 0; c < 50; c++) begin
                @(negedge clk);
                if (w_iack_n === 1'b0) begin ok = 1; break; end
            end
            n_checks++;
            if (!ok || w_iad !== exp_a[k]) begin
                n_fail++; $display("FAIL wrap_addr%0d: got %h (req=%b), expected %h", k, w_iad, ok, exp_a[k]);
            end
            w_acki_n = 1'b0; w_idt = $urandom;
            @(negedge clk); w_acki_n = 1'b1;
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_full();
        test_flush_busy();
        test_flush_ack();
        test_latency();
        test_random();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
